// File: rtl/hb_mem_rd_arbiter.sv
// Round-robin burst read arbiter sharing hb_mem's asynchronous read port between fetch engines.
// Optional macro HB_ARB_BURST_EN: honour req_len (multi-beat bursts); undefined gives single-beat grants.
module hb_mem_rd_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [ADDR_WIDTH-1:0]           mem_r_addr,
    input  logic [DATA_WIDTH-1:0]           mem_r_data,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last,
    output logic                            busy
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SCAN_W = PTR_W + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_owner;
    logic [PTR_W-1:0]       r_addr_owner;
    logic [ADDR_WIDTH-1:0]  r_cur_addr;
    logic                   r_addr_vld;
    logic                   r_addr_last;

    logic [PTR_W-1:0]       w_grant_idx;
    logic                   w_grant_found;
    logic [SCAN_W-1:0]      w_scan;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [PTR_W-1:0]       w_next_ptr;
    logic                   w_grant;
    logic                   w_burst_last;

`ifdef HB_ARB_BURST_EN
    logic [LEN_WIDTH-1:0]   r_beats_left;
    logic [LEN_WIDTH-1:0]   w_sel_len;

    assign w_burst_last = (r_beats_left == '0);

    always_comb begin
        w_sel_len = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == w_grant_idx) begin
                w_sel_len = req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end
`else
    logic                   w_unused_len;

    // Length field is ignored: every grant is exactly one beat.
    assign w_unused_len = ^req_len;
    assign w_burst_last = 1'b1;
`endif

    // First pending requester searching upward from rr_ptr with wrap.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = r_rr_ptr;
        w_scan        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_scan = SCAN_W'(r_rr_ptr) + SCAN_W'(i);
            if (w_scan >= SCAN_W'(NUM_REQ)) begin
                w_scan = w_scan - SCAN_W'(NUM_REQ);
            end
            if (!w_grant_found && req_valid[PTR_W'(w_scan)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = PTR_W'(w_scan);
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == w_grant_idx) begin
                w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_grant_idx + PTR_W'(1));
    assign w_grant    = (r_state == S_IDLE) && w_grant_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_found) begin
                    req_ready    = NUM_REQ'(1) << w_grant_idx;
                    w_next_state = S_BURST;
                end
            end
            S_BURST: begin
                if (w_burst_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Address stage drives hb_mem; response stage captures its combinational data a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_cur_addr   <= '0;
            r_addr_owner <= '0;
            r_addr_vld   <= 1'b0;
            r_addr_last  <= 1'b0;
            mem_r_addr   <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_last     <= 1'b0;
            busy         <= 1'b0;
`ifdef HB_ARB_BURST_EN
            r_beats_left <= '0;
`endif
        end else begin
            if (w_grant) begin
                r_cur_addr <= w_sel_addr;
                r_owner    <= w_grant_idx;
                r_rr_ptr   <= w_next_ptr;
`ifdef HB_ARB_BURST_EN
                r_beats_left <= w_sel_len;
`endif
            end
            if (r_state == S_BURST) begin
                mem_r_addr <= r_cur_addr;
                r_cur_addr <= r_cur_addr + ADDR_WIDTH'(1);
`ifdef HB_ARB_BURST_EN
                if (!w_burst_last) begin
                    r_beats_left <= r_beats_left - LEN_WIDTH'(1);
                end
`endif
            end
            r_addr_vld   <= (r_state == S_BURST);
            r_addr_last  <= (r_state == S_BURST) && w_burst_last;
            r_addr_owner <= r_owner;
            rsp_valid    <= r_addr_vld ? (NUM_REQ'(1) << r_addr_owner) : '0;
            rsp_last     <= r_addr_vld && r_addr_last;
            if (r_addr_vld) begin
                rsp_data <= mem_r_data;
            end
            busy <= (w_next_state == S_BURST);
        end
    end

endmodule
